axi4_lite_regfile: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 23 ++
 rtl/axi4_lite_regfile_decode.sv | 25 ++
 rtl/axi4_lite_regfile.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_lite_regfile.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes,
// write/read engine states and data-path widths.
package axi4_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile_decode.sv
// Address decoder: byte address -> register index plus valid flag.
// Ports: addr_i (byte address), idx_o (register index), valid_o (hit).
module axi4_lite_regfile_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-3:0] word;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign off     = addr_i - BASE_ADDR;
    assign word    = off[ADDR_W-1:2];
    assign idx_o   = word[IDX_W-1:0];
    assign valid_o = (addr_i[1:0] == 2'b00) &&
                     (off[1:0] == 2'b00) &&
                     (word < (ADDR_W-2)'(NUM_REGS));

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with byte-strobe writes, independent
// write/read engines, exported register contents and write pulses.
// Ports: aclk/rst, AXI4-Lite AW/W/B/AR/R slave channels, reg_out, write_pulse.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     aclk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic [3:0]               s_awcache,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [AXI_DATA_W-1:0]    s_wdata,
    input  logic [AXI_STRB_W-1:0]    s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ADDR_W-1:0]        s_araddr,
    input  logic [3:0]               s_arcache,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [AXI_DATA_W-1:0]    s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      write_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic unused_attr;
    assign unused_attr = ^{s_awcache, s_awprot, s_arcache, s_arprot};

    // Register storage
    logic [NUM_REGS-1:0][AXI_DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 write_pulse_q, write_pulse_d;

    // Write engine state
    wr_state_t             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_have_q, aw_have_d;
    logic                  w_have_q, w_have_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;

    // Read engine state
    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    resp_t                 rresp_q, rresp_d;

    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             aw_hit, ar_hit;
    logic             aw_hs, w_hs, ar_hs;

    axi4_lite_regfile_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_aw_dec (
        .addr_i  (awaddr_q),
        .idx_o   (aw_idx),
        .valid_o (aw_hit)
    );

    axi4_lite_regfile_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_ar_dec (
        .addr_i  (s_araddr),
        .idx_o   (ar_idx),
        .valid_o (ar_hit)
    );

    assign aw_hs = awready_q & s_awvalid;
    assign w_hs  = wready_q & s_wvalid;
    assign ar_hs = arready_q & s_arvalid;

    // Write engine: capture AW and W independently, commit one cycle after
    // both are held, then hold the B response until accepted.
    always_comb begin
        wr_state_d    = wr_state_q;
        awready_d     = awready_q;
        wready_d      = wready_q;
        aw_have_d     = aw_have_q;
        w_have_d      = w_have_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        regs_d        = regs_q;
        write_pulse_d = '0;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_have_q && w_have_q) begin
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    aw_have_d  = 1'b0;
                    w_have_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    wr_state_d = WR_RESP;
                    if (aw_hit) begin
                        for (int b = 0; b < AXI_STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                regs_d[aw_idx][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                        write_pulse_d[aw_idx] = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    if (aw_hs) begin
                        aw_have_d = 1'b1;
                        awaddr_d  = s_awaddr;
                    end
                    if (w_hs) begin
                        w_have_d = 1'b1;
                        wdata_d  = s_wdata;
                        wstrb_d  = s_wstrb;
                    end
                    // Also raises both readies on the first cycle out of reset.
                    awready_d = ~aw_have_d;
                    wready_d  = ~w_have_d;
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read engine: regs_q is sampled at the AR edge, so a same-edge write
    // commit is not visible to this read.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_RESP;
                    if (ar_hit) begin
                        rdata_d = regs_q[ar_idx];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            regs_q        <= '0;
            write_pulse_q <= '0;
            wr_state_q    <= WR_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_have_q     <= 1'b0;
            w_have_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rd_state_q    <= RD_IDLE;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
        end else begin
            regs_q        <= regs_d;
            write_pulse_q <= write_pulse_d;
            wr_state_q    <= wr_state_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_have_q     <= aw_have_d;
            w_have_q      <= w_have_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rd_state_q    <= rd_state_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
        end
    end

    assign s_awready   = awready_q;
    assign s_wready    = wready_q;
    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_arready   = arready_q;
    assign s_rvalid    = rvalid_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign reg_out     = regs_q;
    assign write_pulse = write_pulse_q;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Randomised self-checking bench for axi4_lite_regfile against an
// array-based register model.
module tb_axi4_lite_regfile;

    localparam int          NUM  = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic            aclk = 1'b0;
    logic            rst;
    logic [31:0]     s_awaddr;
    logic [3:0]      s_awcache;
    logic [2:0]      s_awprot;
    logic            s_awvalid;
    logic            s_awready;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [31:0]     s_araddr;
    logic [3:0]      s_arcache;
    logic [2:0]      s_arprot;
    logic            s_arvalid;
    logic            s_arready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [32*NUM-1:0] reg_out;
    logic [NUM-1:0]  write_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [NUM];

    always #5 aclk = ~aclk;

    axi4_lite_regfile #(
        .ADDR_W    (32),
        .NUM_REGS  (NUM),
        .BASE_ADDR (BASE)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .s_awaddr    (s_awaddr),
        .s_awcache   (s_awcache),
        .s_awprot    (s_awprot),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_araddr    (s_araddr),
        .s_arcache   (s_arcache),
        .s_arprot    (s_arprot),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .reg_out     (reg_out),
        .write_pulse (write_pulse)
    );

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 == 0) && (off / 4 < NUM);
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < NUM; i++) r[32*i +: 32] = model[i];
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly,
                            input int w_dly, input int stall);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        bit aw_chk = 0, w_chk = 0, ok;
        int cyc = 0, idx = 0;
        logic [NUM-1:0] wp;
        ok = addr_ok(addr);
        if (ok) idx = int'((addr - BASE) / 4);
        wp = ok ? (NUM'(1) << idx) : '0;
        s_bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge aclk);
            if (aw_chk) begin
                chk("awready_drop", s_awready, 0);
                chk("wready_wait", s_wready, 1);
                aw_chk = 0;
            end
            if (w_chk) begin
                chk("wready_drop", s_wready, 0);
                chk("awready_wait", s_awready, 1);
                w_chk = 0;
            end
            s_awvalid = !aw_done && cyc >= aw_dly;
            s_awaddr  = addr;
            s_wvalid  = !w_done && cyc >= w_dly;
            s_wdata   = data;
            s_wstrb   = strb;
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(posedge aclk);
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            aw_chk = hs_aw && !w_done;
            w_chk  = hs_w && !aw_done;
            cyc++;
        end
        if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
        @(negedge aclk);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("b_early", s_bvalid, 0);
        if (ok) model[idx] = merge(model[idx], data, strb);
        @(negedge aclk);
        chk("bvalid", s_bvalid, 1);
        chk("bresp", s_bresp, ok ? 2'b00 : 2'b10);
        chk("wpulse", write_pulse, wp);
        chk("reg_out_w", reg_out, model_flat());
        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            chk("bvalid_stall", s_bvalid, 1);
            chk("bresp_stall", s_bresp, ok ? 2'b00 : 2'b10);
            chk("awready_stall", {s_awready, s_wready}, 2'b00);
            chk("wpulse_stall", write_pulse, 0);
        end
        s_bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_bready = 1'b0;
        chk("bvalid_done", s_bvalid, 0);
        chk("ready_back", {s_awready, s_wready}, 2'b11);
        chk("wpulse_once", write_pulse, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        int n = 0;
        bit ok;
        logic [31:0] exp;
        ok  = addr_ok(addr);
        exp = ok ? model[(addr - BASE) / 4] : 32'h0;
        @(negedge aclk);
        s_rready  = 1'b0;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        while (!s_arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!s_arready) chk("rd_timeout", 0, 1);
        @(posedge aclk);
        @(negedge aclk);
        s_arvalid = 1'b0;
        chk("rvalid", s_rvalid, 1);
        chk("rdata", s_rdata, exp);
        chk("rresp", s_rresp, ok ? 2'b00 : 2'b10);
        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            chk("rvalid_stall", s_rvalid, 1);
            chk("rdata_stall", s_rdata, exp);
            chk("arready_stall", s_arready, 0);
        end
        s_rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_rready = 1'b0;
        chk("rvalid_done", s_rvalid, 0);
        chk("arready_back", s_arready, 1);
    endtask

    task automatic chk_all_zero();
        chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b000);
        chk("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
        chk("rst_resp", {s_bresp, s_rresp}, 4'h0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_wpulse", write_pulse, 0);
        chk("rst_reg_out", reg_out, 0);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        rst = 1'b1;
        s_awaddr = '0; s_awcache = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arcache = '0; s_arprot = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        for (int i = 0; i < NUM; i++) model[i] = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_all_zero();
        rst = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("ready_after_rst", {s_awready, s_wready, s_arready}, 3'b111);

        do_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        chk("reg1_beef", reg_out[63:32], 32'hDEAD_BEEF);
        do_read(BASE + 32'h4, 0);
        do_write(BASE + 32'h4, 32'h1122_3344, 4'b0101, 0, 0, 0);
        chk("reg1_merge", reg_out[63:32], 32'hDE22_BE44);
        do_write(BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 3, 0, 0);
        do_write(BASE + 32'hC, 32'h0BAD_C0DE, 4'hF, 0, 3, 0);
        do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        do_write(BASE + 32'h40, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_write(BASE + 32'h2, 32'h1234_5678, 4'hF, 1, 0, 0);
        do_read(BASE + 32'h40, 0);
        do_read(BASE + 32'h8, 0);
        do_write(BASE + 32'h3C, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
        do_read(BASE + 32'h3C, 5);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = BASE + 4 * $urandom_range(0, NUM - 1);
            else if (r == 7) a = BASE + 32'h40 + 4 * $urandom_range(0, 15);
            else if (r == 8) a = BASE + 4 * $urandom_range(0, NUM - 1)
                                 + $urandom_range(1, 3);
            else             a = 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) != 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            else
                do_read(a, int'($urandom_range(0, 2)));
        end

        // Reset while a B response is pending
        @(negedge aclk);
        s_awaddr = BASE + 32'h14; s_awvalid = 1'b1;
        s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_bready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge aclk);
        chk("pend_bvalid", s_bvalid, 1);
        rst = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk_all_zero();
        rst = 1'b0;
        s_bready = 1'b1;
        for (int i = 0; i < NUM; i++) model[i] = '0;
        repeat (4) begin
            @(negedge aclk);
            chk("no_b_after_rst", s_bvalid, 0);
        end
        s_bready = 1'b0;
        do_read(BASE + 32'h4, 0);
        do_read(BASE + 32'h14, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
